// File: rtl/lab1_idiv_int_div_iter.sv
// rtl/lab1_idiv_int_div_iter.sv - iterative restoring integer divider with val/rdy streams
//
// Purpose:
//    Divides a by b one quotient bit per cycle (restoring algorithm), one
//    transaction in flight. Request accepted in IDLE, p_nbits CALC steps,
//    result held in DONE until the consumer takes it.
//
// Ports:
//    clk          input   1          clock, all state updates on posedge
//    reset        input   1          asynchronous active-low reset
//    istream_val  input   1          request valid
//    istream_rdy  output  1          request ready (high only in IDLE)
//    istream_msg  input   2*p_nbits  [2n-1:n] dividend a, [n-1:0] divisor b
//    ostream_val  output  1          response valid (high only in DONE)
//    ostream_rdy  input   1          response ready
//    ostream_msg  output  2*p_nbits  [2n-1:n] remainder, [n-1:0] quotient
//
// Build option:
//    LAB1_IDIV_SIGNED_EN  two's complement operands, truncation toward zero.
//                         Undefined: unsigned division only.

module lab1_idiv_int_div_iter #(
   parameter int p_nbits = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   istream_val,
   output logic                   istream_rdy,
   input  logic [2*p_nbits-1:0]   istream_msg,
   output logic                   ostream_val,
   input  logic                   ostream_rdy,
   output logic [2*p_nbits-1:0]   ostream_msg
);

   localparam int c_cw = ($clog2(p_nbits) > 0) ? $clog2(p_nbits) : 1;
   localparam logic [c_cw-1:0]    c_last = c_cw'(p_nbits - 1);
   localparam logic [c_cw-1:0]    c_cnt_one = c_cw'(1);
   localparam logic [p_nbits-1:0] c_one = p_nbits'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_cw-1:0]      r_cnt;
   logic [p_nbits-1:0]   r_rem;
   logic [p_nbits-1:0]   r_quo;
   logic [p_nbits-1:0]   r_div;
   logic                 r_istream_rdy;
   logic                 r_ostream_val;
   logic [2*p_nbits-1:0] r_ostream_msg;

   logic [p_nbits-1:0]   w_a;
   logic [p_nbits-1:0]   w_b;
   logic [p_nbits-1:0]   w_a_mag;
   logic [p_nbits-1:0]   w_b_mag;
   logic                 w_accept;
   logic [p_nbits:0]     w_rem_sh;
   logic                 w_ge;
   logic [p_nbits-1:0]   w_sub;
   logic [p_nbits-1:0]   w_rem_nx;
   logic [p_nbits-1:0]   w_quo_nx;
   logic [p_nbits-1:0]   w_rem_fin;
   logic [p_nbits-1:0]   w_quo_fin;

   assign w_a      = istream_msg[2*p_nbits-1:p_nbits];
   assign w_b      = istream_msg[p_nbits-1:0];
   assign w_accept = (r_state == S_IDLE) && r_istream_rdy && istream_val;

   // One restoring step. The shifted partial remainder needs n+1 bits since
   // it can reach 2*divisor-1; the subtraction result always fits n bits
   // whenever it is kept.
   assign w_rem_sh = {r_rem, r_quo[p_nbits-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});
   assign w_sub    = w_rem_sh[p_nbits-1:0] - r_div;
   assign w_rem_nx = w_ge ? w_sub : w_rem_sh[p_nbits-1:0];
   assign w_quo_nx = {r_quo[p_nbits-2:0], w_ge};

`ifdef LAB1_IDIV_SIGNED_EN
   logic                 r_sign_q;
   logic                 r_sign_r;
   logic                 r_b_zero;
   logic [p_nbits-1:0]   r_a_orig;

   // The core always divides magnitudes; -2^(n-1) maps onto itself, which
   // is still the correct unsigned magnitude.
   assign w_a_mag = w_a[p_nbits-1] ? (~w_a + c_one) : w_a;
   assign w_b_mag = w_b[p_nbits-1] ? (~w_b + c_one) : w_b;

   // Sign fixup on the final step; divide by zero returns the original a.
   assign w_quo_fin = r_b_zero ? '1 :
                      (r_sign_q ? (~w_quo_nx + c_one) : w_quo_nx);
   assign w_rem_fin = r_b_zero ? r_a_orig :
                      (r_sign_r ? (~w_rem_nx + c_one) : w_rem_nx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_b_zero <= 1'b0;
         r_a_orig <= '0;
      end else if (w_accept) begin
         r_sign_q <= w_a[p_nbits-1] ^ w_b[p_nbits-1];
         r_sign_r <= w_a[p_nbits-1];
         r_b_zero <= (w_b == '0);
         r_a_orig <= w_a;
      end
   end
`else
   assign w_a_mag   = w_a;
   assign w_b_mag   = w_b;
   assign w_quo_fin = w_quo_nx;
   assign w_rem_fin = w_rem_nx;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_div         <= '0;
         r_istream_rdy <= 1'b0;
         r_ostream_val <= 1'b0;
         r_ostream_msg <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_istream_rdy <= 1'b1;
               r_ostream_val <= 1'b0;
               if (w_accept) begin
                  r_quo         <= w_a_mag;
                  r_div         <= w_b_mag;
                  r_rem         <= '0;
                  r_cnt         <= '0;
                  r_istream_rdy <= 1'b0;
                  r_state       <= S_CALC;
               end
            end
            S_CALC: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt + c_cnt_one;
               if (r_cnt == c_last) begin
                  // Response is captured here so it stays frozen in DONE.
                  r_ostream_msg <= {w_rem_fin, w_quo_fin};
                  r_ostream_val <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            S_DONE: begin
               if (ostream_rdy) begin
                  r_ostream_val <= 1'b0;
                  r_istream_rdy <= 1'b1;
                  r_state       <= S_IDLE;
               end
            end
            default: begin
               r_ostream_val <= 1'b0;
               r_istream_rdy <= 1'b1;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign istream_rdy = r_istream_rdy;
   assign ostream_val = r_ostream_val;
   assign ostream_msg = r_ostream_msg;

endmodule

// File: tb/tb_lab1_idiv_int_div_iter.sv
// tb/tb_lab1_idiv_int_div_iter.sv - scoreboard bench for lab1_idiv_int_div_iter

module tb_lab1_idiv_int_div_iter;

   localparam int N = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           istream_val = 1'b0;
   logic           istream_rdy;
   logic [2*N-1:0] istream_msg = '0;
   logic           ostream_val;
   logic           ostream_rdy = 1'b0;
   logic [2*N-1:0] ostream_msg;

   lab1_idiv_int_div_iter #(.p_nbits(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .istream_msg (istream_msg),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .ostream_msg (ostream_msg)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          hs_cyc = -1;
   int          acc_cyc = -1;
   logic [63:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every response handshake pops one expected value.
   always @(negedge clk) begin
      if (reset && ostream_val && ostream_rdy) begin
         hs_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_response: got %h expected none", ostream_msg);
         end else begin
            check("response", ostream_msg, exp_q.pop_front());
         end
      end
   end

   // Leaves istream_val high; caller decides when to drop it.
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
      int n = 0;
      istream_val = 1'b1;
      istream_msg = {a, b};
      while (!istream_rdy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!istream_rdy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: istream_rdy 0 expected 1");
      end else begin
         acc_cyc = cyc;
         if (push) exp_q.push_back(exp);
         @(posedge clk);
         #1;
         istream_msg = {$urandom, $urandom};
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_val(output int n);
      n = 0;
      while (!ostream_val && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cnt;
      bit          flag;
      logic [63:0] msg0;

      repeat (3) @(negedge clk);
      check("reset_istream_rdy", 64'(istream_rdy), 64'd0);
      check("reset_ostream_val", 64'(ostream_val), 64'd0);
      check("reset_ostream_msg", ostream_msg, 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      ostream_rdy = 1'b1;
      @(negedge clk);

      // Latency and ready-low during CALC/DONE.
      send(32'd20, 32'd3, {32'd2, 32'd6}, 1'b1);
      istream_val = 1'b0;
      cnt = 0;
      flag = 1'b0;
      while (!ostream_val && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (istream_rdy) flag = 1'b1;
      end
      check("latency_cycles", 64'(cnt), 64'd33);
      check("istream_rdy_busy", 64'(flag), 64'd0);
      drain();

      // Divide by zero and edge operands.
      send(32'd7, 32'd0, {32'd7, 32'hFFFFFFFF}, 1'b1);
      send(32'd0, 32'd5, {32'd0, 32'd0}, 1'b1);
      send(32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b1);
      send(32'hFFFFFFFF, 32'hFFFFFFFF, {32'd0, 32'd1}, 1'b1);
`ifndef LAB1_IDIV_SIGNED_EN
      send(32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, 1'b1);
      send(32'd5, 32'hFFFFFFFF, {32'd5, 32'd0}, 1'b1);
`endif
      istream_val = 1'b0;
      drain();

      // Consumer stall: response must hold.
      @(posedge clk); #1;
      ostream_rdy = 1'b0;
      send(32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
      istream_val = 1'b0;
      wait_val(cnt);
      check("stall_val_seen", 64'(ostream_val), 64'd1);
      msg0 = ostream_msg;
      flag = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!ostream_val || ostream_msg !== msg0) flag = 1'b0;
      end
      check("stall_hold", 64'(flag), 64'd1);
      check("stall_msg", ostream_msg, {32'd2, 32'd14});
      @(posedge clk); #1;
      ostream_rdy = 1'b1;
      drain();
      @(negedge clk);
      check("val_after_handshake", 64'(ostream_val), 64'd0);

      // Back-to-back with istream_val held high.
      send(32'd9, 32'd2, {32'd1, 32'd4}, 1'b1);
      send(32'd50, 32'd50, {32'd0, 32'd1}, 1'b1);
      check("b2b_accept_cycle", 64'(acc_cyc), 64'(hs_cyc + 1));
      istream_val = 1'b0;
      drain();

      // Reset in CALC discards the operation.
      send(32'd1000, 32'd3, 64'd0, 1'b0);
      istream_val = 1'b0;
      repeat (15) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_calc_val", 64'(ostream_val), 64'd0);
      check("abort_calc_rdy", 64'(istream_rdy), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      send(32'd10, 32'd4, {32'd2, 32'd2}, 1'b1);
      istream_val = 1'b0;
      drain();

      // Reset in DONE drops valid immediately.
      ostream_rdy = 1'b0;
      send(32'd77, 32'd5, 64'd0, 1'b0);
      istream_val = 1'b0;
      wait_val(cnt);
      check("abort_done_val_seen", 64'(ostream_val), 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_done_val", 64'(ostream_val), 64'd0);
      check("abort_done_msg", ostream_msg, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      ostream_rdy = 1'b1;
      send(32'd13, 32'd4, {32'd1, 32'd3}, 1'b1);
      istream_val = 1'b0;
      drain();

`ifdef LAB1_IDIV_SIGNED_EN
      send(32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
      send(32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b1);
      send(32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1);
      send(32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b1);
      istream_val = 1'b0;
      drain();
`endif

      repeat (40) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
